// File: rtl/ethernet_rx_frame_aligner.sv
// GMII receive front end: strips preamble/SFD and forwards each frame as a
// contiguous 9-bit beat stream with bit 8 marking the first and last byte.
module ethernet_rx_frame_aligner #(
  parameter int unsigned MIN_PREAMBLE_BYTES = 1,
  parameter int unsigned MAX_FRAME_BYTES    = 1522,
  parameter int unsigned COUNTER_WIDTH      = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               gmii_rx_data,
  input  logic                     gmii_rx_valid,
  input  logic                     gmii_rx_error,
  input  logic                     data_ready,
  output logic [8:0]               data,
  output logic                     data_enable,
  output logic [COUNTER_WIDTH-1:0] frame_count,
  output logic [COUNTER_WIDTH-1:0] error_count,
  output logic [COUNTER_WIDTH-1:0] dropped_count
);

  localparam int unsigned BYTE_CNT_W = $clog2(MAX_FRAME_BYTES + 1);
  localparam logic [2:0]  MIN_PRE    = 3'(MIN_PREAMBLE_BYTES);
  localparam logic [BYTE_CNT_W-1:0] MAX_BYTES = BYTE_CNT_W'(MAX_FRAME_BYTES);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [7:0]  PREAMBLE   = 8'h55;
  localparam logic [7:0]  SFD        = 8'hD5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_PAYLOAD,
    S_DROP
  } state_t;

  state_t                  state;
  logic [2:0]              preamble_cnt;
  logic [BYTE_CNT_W-1:0]   byte_cnt;
  logic [7:0]              hold_byte;
  logic                    hold_valid;
  logic                    first_flag;

  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + COUNTER_WIDTH'(1);
  endfunction

  // Frame state machine; the hold register delays payload by one byte so the
  // last byte can be flagged once the end (or abort) of the frame is seen.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      preamble_cnt  <= '0;
      byte_cnt      <= '0;
      hold_byte     <= '0;
      hold_valid    <= 1'b0;
      first_flag    <= 1'b0;
      data          <= '0;
      data_enable   <= 1'b0;
      frame_count   <= '0;
      error_count   <= '0;
      dropped_count <= '0;
    end else begin
      data        <= '0;
      data_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gmii_rx_valid) begin
            if (gmii_rx_data == PREAMBLE) begin
              state        <= S_PREAMBLE;
              preamble_cnt <= 3'd1;
            end else begin
              state <= S_DROP;
            end
          end
        end
        S_PREAMBLE: begin
          if (!gmii_rx_valid) begin
            state <= S_IDLE;
          end else if (gmii_rx_error) begin
            state       <= S_DROP;
            error_count <= sat_inc(error_count);
          end else if (gmii_rx_data == PREAMBLE) begin
            if (preamble_cnt != 3'd7) preamble_cnt <= preamble_cnt + 3'd1;
          end else if ((gmii_rx_data == SFD) && (preamble_cnt >= MIN_PRE)) begin
            if (data_ready) begin
              state      <= S_PAYLOAD;
              first_flag <= 1'b1;
              hold_valid <= 1'b0;
              byte_cnt   <= '0;
            end else begin
              state         <= S_DROP;
              dropped_count <= sat_inc(dropped_count);
            end
          end else begin
            state       <= S_DROP;
            error_count <= sat_inc(error_count);
          end
        end
        S_PAYLOAD: begin
          if (!gmii_rx_valid) begin
            state      <= S_IDLE;
            hold_valid <= 1'b0;
            if (hold_valid) begin
              data        <= {1'b1, hold_byte};
              data_enable <= 1'b1;
              frame_count <= sat_inc(frame_count);
            end else begin
              error_count <= sat_inc(error_count);
            end
          end else if (gmii_rx_error || (byte_cnt == MAX_BYTES)) begin
            // Abort: close the frame on the held byte, drop the offending one.
            state       <= S_DROP;
            hold_valid  <= 1'b0;
            error_count <= sat_inc(error_count);
            if (hold_valid) begin
              data        <= {1'b1, hold_byte};
              data_enable <= 1'b1;
            end
          end else begin
            if (hold_valid) begin
              data        <= {first_flag, hold_byte};
              data_enable <= 1'b1;
              first_flag  <= 1'b0;
            end
            hold_byte  <= gmii_rx_data;
            hold_valid <= 1'b1;
            byte_cnt   <= byte_cnt + BYTE_CNT_W'(1);
          end
        end
        S_DROP: begin
          if (!gmii_rx_valid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_rx_frame_aligner.sv
// Bench for ethernet_rx_frame_aligner: two instances (default and small
// limits) share the GMII stimulus; a frame-level model predicts beats/counts.
module tb_ethernet_rx_frame_aligner;

  localparam int unsigned CW_B  = 3;
  localparam int          MIN_B = 3;
  localparam int          MAX_B = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [7:0]  gmii_rx_data;
  logic        gmii_rx_valid;
  logic        gmii_rx_error;
  logic        data_ready;

  logic [8:0]      data_a, data_b;
  logic            de_a, de_b;
  logic [15:0]     fc_a, ec_a, dc_a;
  logic [CW_B-1:0] fc_b, ec_b, dc_b;

  ethernet_rx_frame_aligner dut_a (
    .clock(clock), .reset(reset), .gmii_rx_data(gmii_rx_data),
    .gmii_rx_valid(gmii_rx_valid), .gmii_rx_error(gmii_rx_error),
    .data_ready(data_ready), .data(data_a), .data_enable(de_a),
    .frame_count(fc_a), .error_count(ec_a), .dropped_count(dc_a)
  );

  ethernet_rx_frame_aligner #(
    .MIN_PREAMBLE_BYTES(MIN_B), .MAX_FRAME_BYTES(MAX_B), .COUNTER_WIDTH(CW_B)
  ) dut_b (
    .clock(clock), .reset(reset), .gmii_rx_data(gmii_rx_data),
    .gmii_rx_valid(gmii_rx_valid), .gmii_rx_error(gmii_rx_error),
    .data_ready(data_ready), .data(data_b), .data_enable(de_b),
    .frame_count(fc_b), .error_count(ec_b), .dropped_count(dc_b)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [8:0]  val;
  } beat_t;

  beat_t q_a[$];
  beat_t q_b[$];
  beat_t hb_a, hb_b;
  int    cyc = 0;
  bit    mon_on = 1'b0;
  int    beat_err_a = 0, beat_err_b = 0;
  logic [8:0] got_a, want_a, got_b, want_b;
  int    ef_a = 0, ee_a = 0, ed_a = 0, ef_b = 0, ee_b = 0, ed_b = 0;
  logic [57:0] snap_a;
  logic [18:0] snap_b;
  int    checks = 0, passes = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Beat monitor: each beat must match the next expected value on its exact cycle.
  always @(negedge clock) begin
    if (mon_on) begin
      if (de_a === 1'b1) begin
        if (q_a.size() == 0) begin
          beat_err_a++; got_a = data_a; want_a = 9'h0;
        end else begin
          hb_a = q_a.pop_front();
          if (hb_a.cyc != 32'(cyc) || hb_a.val !== data_a) begin
            beat_err_a++; got_a = data_a; want_a = hb_a.val;
          end
        end
      end else begin
        if (de_a !== 1'b0 || data_a !== 9'h0) begin
          beat_err_a++; got_a = data_a; want_a = 9'h0;
        end
        if (q_a.size() != 0 && q_a[0].cyc < 32'(cyc)) begin
          beat_err_a++; got_a = data_a; want_a = q_a[0].val; void'(q_a.pop_front());
        end
      end
      if (de_b === 1'b1) begin
        if (q_b.size() == 0) begin
          beat_err_b++; got_b = data_b; want_b = 9'h0;
        end else begin
          hb_b = q_b.pop_front();
          if (hb_b.cyc != 32'(cyc) || hb_b.val !== data_b) begin
            beat_err_b++; got_b = data_b; want_b = hb_b.val;
          end
        end
      end else begin
        if (de_b !== 1'b0 || data_b !== 9'h0) begin
          beat_err_b++; got_b = data_b; want_b = 9'h0;
        end
        if (q_b.size() != 0 && q_b[0].cyc < 32'(cyc)) begin
          beat_err_b++; got_b = data_b; want_b = q_b[0].val; void'(q_b.pop_front());
        end
      end
    end
  end

  // Frame-level outcome: k = beats forwarded, plus one counter delta.
  function automatic void model(input int pre, input logic [7:0] sfd, input bit ready,
                                input int len, input int err_pos, input int minp,
                                input int maxb, output int k, output int dfr,
                                output int der, output int ddr);
    int cut;
    k = 0; dfr = 0; der = 0; ddr = 0;
    if (pre == 0) return;
    if (sfd != 8'hD5 || pre < minp) begin der = 1; return; end
    if (!ready) begin ddr = 1; return; end
    cut = 0;
    if (err_pos > 0 && err_pos <= len) cut = err_pos;
    if (len > maxb && (cut == 0 || maxb + 1 < cut)) cut = maxb + 1;
    if (cut > 0) begin k = cut - 1; der = 1; end
    else if (len == 0) der = 1;
    else begin k = len; dfr = 1; end
  endfunction

  function automatic logic [CW_B-1:0] sat_b(input int v);
    return (v > 7) ? 3'd7 : CW_B'(v);
  endfunction

  task automatic step(input logic v, input logic [7:0] d, input logic e, input logic r,
                      input logic rst, output int edge_n);
    gmii_rx_valid = v; gmii_rx_data = d; gmii_rx_error = e; data_ready = r; reset = rst;
    @(posedge clock);
    #1;
    edge_n = cyc;
  endtask

  task automatic idle(input int n);
    int e;
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0, 1'($urandom), 1'b0, e);
  endtask

  task automatic send_frame(input int pre, input logic [7:0] sfd, input bit ready,
                            input int len, input int err_pos, input int rst_at,
                            input int gap, input bit rnd, input logic [7:0] base);
    int ka, kb, fa, ea, da, fb, eb, db, e;
    logic [7:0] by;
    beat_t hb;
    model(pre, sfd, ready, len, err_pos, 1, 1522, ka, fa, ea, da);
    model(pre, sfd, ready, len, err_pos, MIN_B, MAX_B, kb, fb, eb, db);
    for (int p = 0; p < pre; p++) step(1'b1, 8'h55, 1'b0, 1'($urandom), 1'b0, e);
    step(1'b1, sfd, 1'b0, ready, 1'b0, e);
    for (int i = 1; i <= len; i++) begin
      by = rnd ? 8'($urandom) : base + 8'(i - 1);
      step(1'b1, by, 1'(i == err_pos), 1'($urandom), 1'(i == rst_at), e);
      if (i == rst_at) begin
        snap_a = {de_a, data_a, fc_a, ec_a, dc_a};
        snap_b = {de_b, data_b, fc_b, ec_b, dc_b};
        ef_a = 0; ee_a = 0; ed_a = 0; ef_b = 0; ee_b = 0; ed_b = 0;
      end
      if (rst_at == 0 || i < rst_at - 1) begin
        hb.cyc = 32'(e + 1);
        if (i <= ka) begin hb.val = {1'(i == 1 || i == ka), by}; q_a.push_back(hb); end
        if (i <= kb) begin hb.val = {1'(i == 1 || i == kb), by}; q_b.push_back(hb); end
      end
    end
    for (int g = 0; g < gap; g++) step(1'b0, 8'($urandom), 1'b0, 1'($urandom), 1'b0, e);
    if (rst_at == 0) begin
      ef_a += fa; ee_a += ea; ed_a += da; ef_b += fb; ee_b += eb; ed_b += db;
    end
  endtask

  task automatic test_reset();
    int e;
    gmii_rx_valid = 1'b0; gmii_rx_data = 8'h00; gmii_rx_error = 1'b0; data_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, e);
    mon_on = 1'b1;
    checks++;
    if ({de_a, data_a, fc_a, ec_a, dc_a} !== 58'h0)
      $display("FAIL reset_a: got %h required 0", {de_a, data_a, fc_a, ec_a, dc_a});
    else passes++;
    checks++;
    if ({de_b, data_b, fc_b, ec_b, dc_b} !== 19'h0)
      $display("FAIL reset_b: got %h required 0", {de_b, data_b, fc_b, ec_b, dc_b});
    else passes++;
    idle(2);
  endtask

  task automatic test_basic();
    send_frame(7, 8'hD5, 1'b1, 64, 0, 0, 1, 1'b0, 8'h00);
    idle(3);
    checks++;
    if (beat_err_a !== 0 || q_a.size() !== 0)
      $display("FAIL basic beats_a: %0d bad (got %h want %h), %0d missing, required 0", beat_err_a, got_a, want_a, q_a.size());
    else passes++;
    checks++;
    if (beat_err_b !== 0 || q_b.size() !== 0)
      $display("FAIL basic beats_b: %0d bad (got %h want %h), %0d missing, required 0", beat_err_b, got_b, want_b, q_b.size());
    else passes++;
    checks++;
    if ({fc_a, ec_a, dc_a} !== {16'(ef_a), 16'(ee_a), 16'(ed_a)})
      $display("FAIL basic counters_a: got %0d/%0d/%0d required %0d/%0d/%0d", fc_a, ec_a, dc_a, ef_a, ee_a, ed_a);
    else passes++;
    checks++;
    if ({fc_b, ec_b, dc_b} !== {sat_b(ef_b), sat_b(ee_b), sat_b(ed_b)})
      $display("FAIL basic counters_b: got %0d/%0d/%0d required %0d/%0d/%0d", fc_b, ec_b, dc_b, sat_b(ef_b), sat_b(ee_b), sat_b(ed_b));
    else passes++;
    beat_err_a = 0; beat_err_b = 0; q_a.delete(); q_b.delete();
  endtask

  task automatic test_drop_ready();
    send_frame(7, 8'hD5, 1'b0, 64, 0, 0, 2, 1'b0, 8'h00);
    send_frame(7, 8'hD5, 1'b1, 64, 0, 0, 1, 1'b0, 8'h00);
    idle(3);
    checks++;
    if (beat_err_a !== 0 || q_a.size() !== 0)
      $display("FAIL drop_ready beats_a: %0d bad (got %h want %h), %0d missing, required 0", beat_err_a, got_a, want_a, q_a.size());
    else passes++;
    checks++;
    if (beat_err_b !== 0 || q_b.size() !== 0)
      $display("FAIL drop_ready beats_b: %0d bad (got %h want %h), %0d missing, required 0", beat_err_b, got_b, want_b, q_b.size());
    else passes++;
    checks++;
    if ({fc_a, ec_a, dc_a} !== {16'(ef_a), 16'(ee_a), 16'(ed_a)})
      $display("FAIL drop_ready counters_a: got %0d/%0d/%0d required %0d/%0d/%0d", fc_a, ec_a, dc_a, ef_a, ee_a, ed_a);
    else passes++;
    checks++;
    if ({fc_b, ec_b, dc_b} !== {sat_b(ef_b), sat_b(ee_b), sat_b(ed_b)})
      $display("FAIL drop_ready counters_b: got %0d/%0d/%0d required %0d/%0d/%0d", fc_b, ec_b, dc_b, sat_b(ef_b), sat_b(ee_b), sat_b(ed_b));
    else passes++;
    beat_err_a = 0; beat_err_b = 0; q_a.delete(); q_b.delete();
  endtask

  task automatic test_rx_error();
    send_frame(7, 8'hD5, 1'b1, 20, 10, 0, 2, 1'b1, 8'h00);
    send_frame(7, 8'hD5, 1'b1, 12, 1, 0, 1, 1'b1, 8'h00);
    idle(3);
    checks++;
    if (beat_err_a !== 0 || q_a.size() !== 0)
      $display("FAIL rx_error beats_a: %0d bad (got %h want %h), %0d missing, required 0", beat_err_a, got_a, want_a, q_a.size());
    else passes++;
    checks++;
    if (beat_err_b !== 0 || q_b.size() !== 0)
      $display("FAIL rx_error beats_b: %0d bad (got %h want %h), %0d missing, required 0", beat_err_b, got_b, want_b, q_b.size());
    else passes++;
    checks++;
    if ({fc_a, ec_a, dc_a} !== {16'(ef_a), 16'(ee_a), 16'(ed_a)})
      $display("FAIL rx_error counters_a: got %0d/%0d/%0d required %0d/%0d/%0d", fc_a, ec_a, dc_a, ef_a, ee_a, ed_a);
    else passes++;
    checks++;
    if ({fc_b, ec_b, dc_b} !== {sat_b(ef_b), sat_b(ee_b), sat_b(ed_b)})
      $display("FAIL rx_error counters_b: got %0d/%0d/%0d required %0d/%0d/%0d", fc_b, ec_b, dc_b, sat_b(ef_b), sat_b(ee_b), sat_b(ed_b));
    else passes++;
    beat_err_a = 0; beat_err_b = 0; q_a.delete(); q_b.delete();
  endtask

  task automatic test_overlength();
    send_frame(7, 8'hD5, 1'b1, 20, 0, 0, 1, 1'b1, 8'h00);
    send_frame(5, 8'hD5, 1'b1, 16, 0, 0, 1, 1'b1, 8'h00);
    send_frame(5, 8'hD5, 1'b1, 17, 0, 0, 1, 1'b1, 8'h00);
    idle(3);
    checks++;
    if (beat_err_a !== 0 || q_a.size() !== 0)
      $display("FAIL overlength beats_a: %0d bad (got %h want %h), %0d missing, required 0", beat_err_a, got_a, want_a, q_a.size());
    else passes++;
    checks++;
    if (beat_err_b !== 0 || q_b.size() !== 0)
      $display("FAIL overlength beats_b: %0d bad (got %h want %h), %0d missing, required 0", beat_err_b, got_b, want_b, q_b.size());
    else passes++;
    checks++;
    if ({fc_a, ec_a, dc_a} !== {16'(ef_a), 16'(ee_a), 16'(ed_a)})
      $display("FAIL overlength counters_a: got %0d/%0d/%0d required %0d/%0d/%0d", fc_a, ec_a, dc_a, ef_a, ee_a, ed_a);
    else passes++;
    checks++;
    if ({fc_b, ec_b, dc_b} !== {sat_b(ef_b), sat_b(ee_b), sat_b(ed_b)})
      $display("FAIL overlength counters_b: got %0d/%0d/%0d required %0d/%0d/%0d", fc_b, ec_b, dc_b, sat_b(ef_b), sat_b(ee_b), sat_b(ed_b));
    else passes++;
    beat_err_a = 0; beat_err_b = 0; q_a.delete(); q_b.delete();
  endtask

  task automatic test_bad_preamble();
    send_frame(2, 8'hAA, 1'b1, 10, 0, 0, 1, 1'b1, 8'h00);
    send_frame(1, 8'hD5, 1'b1, 8, 0, 0, 1, 1'b1, 8'h00);
    send_frame(7, 8'hD5, 1'b1, 1, 0, 0, 1, 1'b0, 8'hAB);
    send_frame(7, 8'hD5, 1'b1, 0, 0, 0, 1, 1'b0, 8'h00);
    send_frame(0, 8'h12, 1'b1, 6, 0, 0, 1, 1'b1, 8'h00);
    idle(3);
    checks++;
    if (beat_err_a !== 0 || q_a.size() !== 0)
      $display("FAIL bad_preamble beats_a: %0d bad (got %h want %h), %0d missing, required 0", beat_err_a, got_a, want_a, q_a.size());
    else passes++;
    checks++;
    if (beat_err_b !== 0 || q_b.size() !== 0)
      $display("FAIL bad_preamble beats_b: %0d bad (got %h want %h), %0d missing, required 0", beat_err_b, got_b, want_b, q_b.size());
    else passes++;
    checks++;
    if ({fc_a, ec_a, dc_a} !== {16'(ef_a), 16'(ee_a), 16'(ed_a)})
      $display("FAIL bad_preamble counters_a: got %0d/%0d/%0d required %0d/%0d/%0d", fc_a, ec_a, dc_a, ef_a, ee_a, ed_a);
    else passes++;
    checks++;
    if ({fc_b, ec_b, dc_b} !== {sat_b(ef_b), sat_b(ee_b), sat_b(ed_b)})
      $display("FAIL bad_preamble counters_b: got %0d/%0d/%0d required %0d/%0d/%0d", fc_b, ec_b, dc_b, sat_b(ef_b), sat_b(ee_b), sat_b(ed_b));
    else passes++;
    beat_err_a = 0; beat_err_b = 0; q_a.delete(); q_b.delete();
  endtask

  task automatic test_back_to_back();
    send_frame(7, 8'hD5, 1'b1, 9, 0, 0, 1, 1'b1, 8'h00);
    send_frame(3, 8'hD5, 1'b1, 14, 0, 0, 1, 1'b1, 8'h00);
    send_frame(3, 8'hD5, 1'b1, 2, 0, 0, 1, 1'b1, 8'h00);
    idle(3);
    checks++;
    if (beat_err_a !== 0 || q_a.size() !== 0)
      $display("FAIL back_to_back beats_a: %0d bad (got %h want %h), %0d missing, required 0", beat_err_a, got_a, want_a, q_a.size());
    else passes++;
    checks++;
    if (beat_err_b !== 0 || q_b.size() !== 0)
      $display("FAIL back_to_back beats_b: %0d bad (got %h want %h), %0d missing, required 0", beat_err_b, got_b, want_b, q_b.size());
    else passes++;
    checks++;
    if ({fc_a, ec_a, dc_a} !== {16'(ef_a), 16'(ee_a), 16'(ed_a)})
      $display("FAIL back_to_back counters_a: got %0d/%0d/%0d required %0d/%0d/%0d", fc_a, ec_a, dc_a, ef_a, ee_a, ed_a);
    else passes++;
    checks++;
    if ({fc_b, ec_b, dc_b} !== {sat_b(ef_b), sat_b(ee_b), sat_b(ed_b)})
      $display("FAIL back_to_back counters_b: got %0d/%0d/%0d required %0d/%0d/%0d", fc_b, ec_b, dc_b, sat_b(ef_b), sat_b(ee_b), sat_b(ed_b));
    else passes++;
    beat_err_a = 0; beat_err_b = 0; q_a.delete(); q_b.delete();
  endtask

  task automatic test_mid_reset();
    send_frame(7, 8'hD5, 1'b1, 20, 0, 5, 1, 1'b0, 8'h00);
    checks++;
    if (snap_a !== 58'h0) $display("FAIL mid_reset snap_a: got %h required 0", snap_a);
    else passes++;
    checks++;
    if (snap_b !== 19'h0) $display("FAIL mid_reset snap_b: got %h required 0", snap_b);
    else passes++;
    send_frame(7, 8'hD5, 1'b1, 12, 0, 0, 1, 1'b1, 8'h00);
    idle(3);
    checks++;
    if (beat_err_a !== 0 || q_a.size() !== 0)
      $display("FAIL mid_reset beats_a: %0d bad (got %h want %h), %0d missing, required 0", beat_err_a, got_a, want_a, q_a.size());
    else passes++;
    checks++;
    if (beat_err_b !== 0 || q_b.size() !== 0)
      $display("FAIL mid_reset beats_b: %0d bad (got %h want %h), %0d missing, required 0", beat_err_b, got_b, want_b, q_b.size());
    else passes++;
    checks++;
    if ({fc_a, ec_a, dc_a} !== {16'(ef_a), 16'(ee_a), 16'(ed_a)})
      $display("FAIL mid_reset counters_a: got %0d/%0d/%0d required %0d/%0d/%0d", fc_a, ec_a, dc_a, ef_a, ee_a, ed_a);
    else passes++;
    checks++;
    if ({fc_b, ec_b, dc_b} !== {sat_b(ef_b), sat_b(ee_b), sat_b(ed_b)})
      $display("FAIL mid_reset counters_b: got %0d/%0d/%0d required %0d/%0d/%0d", fc_b, ec_b, dc_b, sat_b(ef_b), sat_b(ee_b), sat_b(ed_b));
    else passes++;
    beat_err_a = 0; beat_err_b = 0; q_a.delete(); q_b.delete();
  endtask

  task automatic test_random();
    int pre, len, err_pos;
    logic [7:0] sfd;
    bit ready;
    for (int n = 0; n < 40; n++) begin
      pre = $urandom_range(0, 8);
      sfd = 8'hD5;
      if ($urandom_range(0, 5) == 0) begin
        sfd = 8'($urandom);
        if (sfd == 8'h55 || sfd == 8'hD5) sfd = 8'hA5;
      end
      ready   = ($urandom_range(0, 6) != 0);
      len     = $urandom_range(0, 40);
      err_pos = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 1) : 0;
      send_frame(pre, sfd, ready, len, err_pos, 0, $urandom_range(1, 3), 1'b1, 8'h00);
    end
    idle(3);
    checks++;
    if (beat_err_a !== 0 || q_a.size() !== 0)
      $display("FAIL random beats_a: %0d bad (got %h want %h), %0d missing, required 0", beat_err_a, got_a, want_a, q_a.size());
    else passes++;
    checks++;
    if (beat_err_b !== 0 || q_b.size() !== 0)
      $display("FAIL random beats_b: %0d bad (got %h want %h), %0d missing, required 0", beat_err_b, got_b, want_b, q_b.size());
    else passes++;
    checks++;
    if ({fc_a, ec_a, dc_a} !== {16'(ef_a), 16'(ee_a), 16'(ed_a)})
      $display("FAIL random counters_a: got %0d/%0d/%0d required %0d/%0d/%0d", fc_a, ec_a, dc_a, ef_a, ee_a, ed_a);
    else passes++;
    checks++;
    if ({fc_b, ec_b, dc_b} !== {sat_b(ef_b), sat_b(ee_b), sat_b(ed_b)})
      $display("FAIL random counters_b: got %0d/%0d/%0d required %0d/%0d/%0d", fc_b, ec_b, dc_b, sat_b(ef_b), sat_b(ee_b), sat_b(ed_b));
    else passes++;
    beat_err_a = 0; beat_err_b = 0; q_a.delete(); q_b.delete();
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 9; n++) send_frame(2, 8'h00, 1'b1, 0, 0, 0, 1, 1'b1, 8'h00);
    for (int n = 0; n < 9; n++) send_frame(7, 8'hD5, 1'b0, 3, 0, 0, 1, 1'b1, 8'h00);
    for (int n = 0; n < 9; n++) send_frame(4, 8'hD5, 1'b1, 4, 0, 0, 1, 1'b1, 8'h00);
    idle(3);
    checks++;
    if (beat_err_a !== 0 || q_a.size() !== 0)
      $display("FAIL saturation beats_a: %0d bad (got %h want %h), %0d missing, required 0", beat_err_a, got_a, want_a, q_a.size());
    else passes++;
    checks++;
    if (beat_err_b !== 0 || q_b.size() !== 0)
      $display("FAIL saturation beats_b: %0d bad (got %h want %h), %0d missing, required 0", beat_err_b, got_b, want_b, q_b.size());
    else passes++;
    checks++;
    if ({fc_a, ec_a, dc_a} !== {16'(ef_a), 16'(ee_a), 16'(ed_a)})
      $display("FAIL saturation counters_a: got %0d/%0d/%0d required %0d/%0d/%0d", fc_a, ec_a, dc_a, ef_a, ee_a, ed_a);
    else passes++;
    checks++;
    if ({fc_b, ec_b, dc_b} !== {sat_b(ef_b), sat_b(ee_b), sat_b(ed_b)})
      $display("FAIL saturation counters_b: got %0d/%0d/%0d required %0d/%0d/%0d", fc_b, ec_b, dc_b, sat_b(ef_b), sat_b(ee_b), sat_b(ed_b));
    else passes++;
    beat_err_a = 0; beat_err_b = 0; q_a.delete(); q_b.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drop_ready();
    test_rx_error();
    test_overlength();
    test_bad_preamble();
    test_back_to_back();
    test_mid_reset();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ethernet_rx_frame_aligner.md
Name: ethernet_rx_frame_aligner

Overview:
Front-end receive stage between the GMII receive interface and the Ethernet packet parser. It strips preamble and SFD and delivers each frame's bytes (destination MAC through FCS) as a contiguous 9-bit stream (data, data_enable). Bit 8 flags the first byte and the last byte of every frame. Frames are dropped whole when the parser is not ready at SFD time, and frames are aborted on GMII errors or over-length. Saturating statistics counters are provided.

Parameters:
MIN_PREAMBLE_BYTES, 1, number of 0x55 bytes that must precede 0xD5 for the SFD to be accepted (1..7)
MAX_FRAME_BYTES, 1522, maximum post-SFD bytes forwarded per frame
COUNTER_WIDTH, 16, width of each statistics counter

Ports:
clock  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
gmii_rx_data  input  8  received byte
gmii_rx_valid  input  1  GMII RX_DV
gmii_rx_error  input  1  GMII RX_ER
data_ready  input  1  parser ready; sampled only on the SFD cycle
data  output  9  [7:0] frame byte; [8]=1 on the first and last byte of the frame
data_enable  output  1  data is valid this cycle
frame_count  output  COUNTER_WIDTH  frames forwarded and terminated normally
error_count  output  COUNTER_WIDTH  frames aborted (bad preamble, rx_error, over-length)
dropped_count  output  COUNTER_WIDTH  frames discarded because data_ready=0 at SFD

Behaviour:
- One clock domain; synchronous, active-high reset.
- Reset: data=0, data_enable=0, all counters=0, state=S_IDLE, hold register empty, preamble and byte counters 0.
- A reset asserted mid-frame drops the remainder of that frame: the first post-reset byte that is not 0x55 sends the block to S_DROP without counting an error.
- States:
  - S_IDLE: if rx_valid & byte==0x55, go to S_PREAMBLE with preamble_cnt=1. If rx_valid & any other byte, go to S_DROP with no counter change.
  - S_PREAMBLE:
    - 0x55: preamble_cnt++, saturating at 7.
    - 0xD5 with preamble_cnt>=MIN_PREAMBLE_BYTES: if data_ready=1, go to S_PAYLOAD and set first_flag; if data_ready=0, go to S_DROP and increment dropped_count.
    - 0xD5 with too few preamble bytes, any other byte, or rx_error=1: go to S_DROP and increment error_count.
    - rx_valid=0: go to S_IDLE with no count.
  - S_PAYLOAD: a one-byte hold register provides the lookahead needed to mark the last byte.
    - On each sampled byte, the previously held byte (if any) is emitted with data[8]=first_flag; first_flag is then cleared and the new byte is held. byte_cnt++.
    - rx_valid=0 (normal end): emit the held byte with data[8]=1, increment frame_count, go to S_IDLE.
    - rx_error=1 while rx_valid=1: emit the held byte with data[8]=1, discard the errored byte, increment error_count, go to S_DROP.
    - Byte number MAX_FRAME_BYTES+1 arrives: same handling as rx_error.
    - A one-byte frame emits a single beat with data[8]=1.
    - SFD immediately followed by rx_valid=0 (zero payload bytes) emits nothing, increments error_count, returns to S_IDLE.
  - S_DROP: when rx_valid=0, go to S_IDLE; nothing is emitted.
- Output timing:
  - A payload byte sampled at edge E appears on data, data_enable after edge E+1.
  - Frame beats are strictly contiguous: data_enable has no gaps within a frame and stays low for at least 1 cycle between frames.
  - data and data_enable are registered outputs; data is 0 when data_enable=0.
- rx_error outside S_PREAMBLE and S_PAYLOAD is ignored.
- An inter-frame gap of a single cycle is supported, back-to-back with the final beat.
- Counters saturate at all-ones; there is no wrap-around.

Test Plan:
- 7x0x55, 0xD5, 64 bytes 0x00..0x3F, then rx_valid=0 -> data_enable high for exactly 64 consecutive cycles starting 1 cycle after the first payload byte; first beat data=0x100, middle beats 0x001..0x03E, last beat 0x13F; frame_count=1, other counters 0.
- Same frame with data_ready=0 during the SFD cycle -> no data_enable, dropped_count=1; an identical following frame with data_ready=1 is forwarded in full and frame_count=1.
- 20-byte frame with rx_error=1 on byte 10 -> exactly 9 beats, beat 9 = {1, byte 9 value}, error_count=1, no further beats until the next preamble.
- MAX_FRAME_BYTES=16 and a 20-byte frame -> 16 beats, beat 16 has data[8]=1, error_count=1, frame_count=0.
- Preamble 0x55, 0x55, 0xAA, … -> nothing emitted, error_count=1. MIN_PREAMBLE_BYTES=3 with 0x55, 0xD5 -> error_count=1. 1-byte frame 0xAB -> single beat 0x1AB.
- Two frames separated by a 1-cycle gap -> both delivered intact, frame_count=2. Reset pulsed at payload byte 5 -> outputs and counters 0 next cycle, no further beats, next valid frame forwarded normally.
